// File: rtl/note_sequencer_pkg.sv
// Shared types and defaults for the note sequencer and its sample-clock divider.
package note_sequencer_pkg;

  localparam int unsigned DEF_CLK_DIV = 1042;
  localparam int unsigned DEF_ADDR_W  = 20;
  localparam int unsigned DEF_CNT_W   = 16;

  typedef enum logic [2:0] {
    ST_INIT = 3'd0,
    ST_IDLE = 3'd1,
    ST_ARM  = 3'd2,
    ST_PLAY = 3'd3,
    ST_DONE = 3'd4
  } seq_state_t;

endpackage

// File: rtl/note_sequencer_if.sv
// Key-request and controller-handshake bundle between the keyboard/controller side and the sequencer.
interface note_sequencer_if
  import note_sequencer_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned CNT_W  = DEF_CNT_W
) ();

  logic              key_valid;
  logic              key_ready;
  logic [ADDR_W-1:0] note_base;
  logic [CNT_W-1:0]  note_len;
  logic              increment;
  logic              count_inc;
  logic              ctrl_init;
  logic              new_note;
  logic              sample_clk;
  logic              count_done;
  logic [ADDR_W-1:0] sample_addr;
  logic              busy;

  modport master (
    output key_valid, note_base, note_len, increment, count_inc,
    input  key_ready, ctrl_init, new_note, sample_clk, count_done, sample_addr, busy
  );

  modport slave (
    input  key_valid, note_base, note_len, increment, count_inc,
    output key_ready, ctrl_init, new_note, sample_clk, count_done, sample_addr, busy
  );

endinterface

// File: rtl/sample_clk_divider.sv
// Free-running divider producing the sample_clk level (high for the upper half of each period).
module sample_clk_divider
  import note_sequencer_pkg::*;
#(
  parameter int unsigned CLK_DIV = DEF_CLK_DIV
) (
  input  logic Clk,
  input  logic Reset,
  output logic sample_clk,
  output logic tick
);

  localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] HALF = DIV_W'(CLK_DIV / 2);

  logic [DIV_W-1:0] div_cnt;
  logic [DIV_W-1:0] div_next;

  always_comb begin
    div_next = (div_cnt == LAST) ? '0 : div_cnt + DIV_W'(1);
  end

  // sample_clk is registered from the next count so it always matches div_cnt >= HALF
  always_ff @(posedge Clk) begin
    if (Reset) begin
      div_cnt    <= '0;
      sample_clk <= 1'b0;
    end else begin
      div_cnt    <= div_next;
      sample_clk <= (div_next >= HALF);
    end
  end

  assign tick = (div_cnt == LAST);

endmodule

// File: rtl/note_sequencer.sv
// Note-side sequencer: accepts key requests, announces notes, and walks the sample address/count.
module note_sequencer
  import note_sequencer_pkg::*;
#(
  parameter int unsigned CLK_DIV = DEF_CLK_DIV,
  parameter int unsigned ADDR_W  = DEF_ADDR_W,
  parameter int unsigned CNT_W   = DEF_CNT_W
) (
  input  logic Clk,
  input  logic Reset,
  note_sequencer_if.slave bus
);

  localparam logic [2:0] S_INIT = ST_INIT;
  localparam logic [2:0] S_IDLE = ST_IDLE;
  localparam logic [2:0] S_ARM  = ST_ARM;
  localparam logic [2:0] S_PLAY = ST_PLAY;
  localparam logic [2:0] S_DONE = ST_DONE;

  logic [2:0]        state, state_d;
  logic              ctrl_init_q, ctrl_init_d;
  logic              new_note_q, new_note_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [CNT_W-1:0]  len_q, len_d;
  logic              count_done;
  logic              div_tick_unused;

  sample_clk_divider #(.CLK_DIV(CLK_DIV)) u_div (
    .Clk        (Clk),
    .Reset      (Reset),
    .sample_clk (bus.sample_clk),
    .tick       (div_tick_unused)
  );

  // Done only counts while a note is live; IDLE keeps the stale count from the last note
  assign count_done = ((state == S_PLAY) || (state == S_DONE)) && (count_q >= len_q);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state       <= S_INIT;
      ctrl_init_q <= 1'b0;
      new_note_q  <= 1'b0;
      addr_q      <= '0;
      count_q     <= '0;
      len_q       <= CNT_W'(1);
    end else begin
      state       <= state_d;
      ctrl_init_q <= ctrl_init_d;
      new_note_q  <= new_note_d;
      addr_q      <= addr_d;
      count_q     <= count_d;
      len_q       <= len_d;
    end
  end

  always_comb begin
    state_d     = state;
    ctrl_init_d = 1'b0;
    new_note_d  = 1'b0;
    addr_d      = addr_q;
    count_d     = count_q;
    len_d       = len_q;
    case (state)
      // INIT holds one extra cycle so the init pulse is seen while still in INIT
      S_INIT: begin
        if (!ctrl_init_q) ctrl_init_d = 1'b1;
        else              state_d     = S_IDLE;
      end
      S_IDLE: begin
        if (bus.key_valid) begin
          addr_d     = bus.note_base;
          count_d    = '0;
          len_d      = (bus.note_len == '0) ? CNT_W'(1) : bus.note_len;
          new_note_d = 1'b1;
          state_d    = S_ARM;
        end
      end
      S_ARM: state_d = S_PLAY;
      S_PLAY: begin
        if (bus.increment) addr_d = addr_q + ADDR_W'(1);
        if (bus.count_inc && (count_q < len_q)) count_d = count_q + CNT_W'(1);
        if (count_done) state_d = S_DONE;
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_INIT;
    endcase
  end

  assign bus.key_ready   = (state == S_IDLE);
  assign bus.busy        = (state == S_ARM) || (state == S_PLAY);
  assign bus.count_done  = count_done;
  assign bus.ctrl_init   = ctrl_init_q;
  assign bus.new_note    = new_note_q;
  assign bus.sample_addr = addr_q;

endmodule

// File: tb/tb_note_sequencer.sv
// Directed self-checking bench for note_sequencer with a short sample-clock divider.
module tb_note_sequencer;
  import note_sequencer_pkg::*;

  localparam int unsigned ADDR_W  = 20;
  localparam int unsigned CNT_W   = 16;
  localparam int unsigned CLK_DIV = 8;

  logic Clk   = 1'b0;
  logic Reset = 1'b1;
  int   errors = 0;
  int   checks = 0;

  note_sequencer_if #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) bus ();

  note_sequencer #(.CLK_DIV(CLK_DIV), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus.slave)
  );

  always #5 Clk = ~Clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic pulse(input logic inc, input logic cinc);
    bus.increment = inc;
    bus.count_inc = cinc;
    step();
    bus.increment = 1'b0;
    bus.count_inc = 1'b0;
  endtask

  task automatic accept_note(input logic [ADDR_W-1:0] base, input logic [CNT_W-1:0] len);
    bus.key_valid = 1'b1;
    bus.note_base = base;
    bus.note_len  = len;
    step();
    bus.key_valid = 1'b0;
  endtask

  task automatic test_reset();
    logic exp_sc;
    Reset = 1'b1;
    repeat (3) step();
    checks++; if ({bus.ctrl_init, bus.key_ready, bus.busy, bus.count_done, bus.new_note, bus.sample_clk} !== 6'b0) begin errors++; $display("FAIL reset_flags: got %b exp 000000", {bus.ctrl_init, bus.key_ready, bus.busy, bus.count_done, bus.new_note, bus.sample_clk}); end
    checks++; if (bus.sample_addr !== 20'h0) begin errors++; $display("FAIL reset_addr: got %h exp 00000", bus.sample_addr); end
    Reset = 1'b0;
    for (int n = 1; n <= 16; n++) begin
      step();
      exp_sc = ((n % CLK_DIV) >= (CLK_DIV / 2));
      checks++; if (bus.sample_clk !== exp_sc) begin errors++; $display("FAIL sample_clk n=%0d: got %b exp %b", n, bus.sample_clk, exp_sc); end
      if (n == 1) begin
        checks++; if ({bus.ctrl_init, bus.key_ready} !== 2'b10) begin errors++; $display("FAIL init_pulse: ctrl_init,key_ready got %b exp 10", {bus.ctrl_init, bus.key_ready}); end
      end else if (n == 2) begin
        checks++; if ({bus.ctrl_init, bus.key_ready} !== 2'b01) begin errors++; $display("FAIL init_to_idle: ctrl_init,key_ready got %b exp 01", {bus.ctrl_init, bus.key_ready}); end
      end else begin
        checks++; if (bus.ctrl_init !== 1'b0) begin errors++; $display("FAIL init_once n=%0d: ctrl_init got %b exp 0", n, bus.ctrl_init); end
      end
    end
  endtask

  task automatic test_basic_note();
    logic [ADDR_W-1:0] exp_addr;
    checks++; if (bus.key_ready !== 1'b1) begin errors++; $display("FAIL basic_ready: got %b exp 1", bus.key_ready); end
    accept_note(20'h00100, 16'd3);
    checks++; if ({bus.new_note, bus.busy, bus.key_ready} !== 3'b110) begin errors++; $display("FAIL basic_arm: new_note,busy,key_ready got %b exp 110", {bus.new_note, bus.busy, bus.key_ready}); end
    checks++; if (bus.sample_addr !== 20'h00100) begin errors++; $display("FAIL basic_base: got %h exp 00100", bus.sample_addr); end
    step();
    checks++; if (bus.new_note !== 1'b0) begin errors++; $display("FAIL basic_new_note_once: got %b exp 0", bus.new_note); end
    for (int i = 0; i < 3; i++) begin
      pulse(1'b1, 1'b1);
      exp_addr = 20'h00101 + ADDR_W'(i);
      checks++; if (bus.sample_addr !== exp_addr) begin errors++; $display("FAIL basic_addr i=%0d: got %h exp %h", i, bus.sample_addr, exp_addr); end
      checks++; if (bus.count_done !== (i == 2)) begin errors++; $display("FAIL basic_done i=%0d: got %b exp %b", i, bus.count_done, (i == 2)); end
    end
    step();
    checks++; if ({bus.count_done, bus.busy, bus.key_ready} !== 3'b100) begin errors++; $display("FAIL basic_done_state: count_done,busy,key_ready got %b exp 100", {bus.count_done, bus.busy, bus.key_ready}); end
    step();
    checks++; if ({bus.count_done, bus.busy, bus.key_ready} !== 3'b001) begin errors++; $display("FAIL basic_idle: count_done,busy,key_ready got %b exp 001", {bus.count_done, bus.busy, bus.key_ready}); end
    checks++; if (bus.sample_addr !== 20'h00103) begin errors++; $display("FAIL basic_final_addr: got %h exp 00103", bus.sample_addr); end
  endtask

  task automatic test_len_zero();
    accept_note(20'h00040, 16'd0);
    pulse(1'b1, 1'b1);
    checks++; if ({bus.count_done, bus.new_note, bus.busy} !== 3'b001) begin errors++; $display("FAIL arm_ignore: count_done,new_note,busy got %b exp 001", {bus.count_done, bus.new_note, bus.busy}); end
    checks++; if (bus.sample_addr !== 20'h00040) begin errors++; $display("FAIL arm_ignore_addr: got %h exp 00040", bus.sample_addr); end
    pulse(1'b0, 1'b1);
    checks++; if (bus.count_done !== 1'b1) begin errors++; $display("FAIL len0_done: got %b exp 1", bus.count_done); end
    step();
    step();
    checks++; if ({bus.count_done, bus.key_ready} !== 2'b01) begin errors++; $display("FAIL len0_idle: count_done,key_ready got %b exp 01", {bus.count_done, bus.key_ready}); end
    pulse(1'b1, 1'b1);
    checks++; if ({bus.sample_addr, bus.busy} !== {20'h00040, 1'b0}) begin errors++; $display("FAIL idle_ignore: addr,busy got %h,%b exp 00040,0", bus.sample_addr, bus.busy); end
  endtask

  task automatic test_wrap_and_pending_key();
    accept_note(20'hFFFFF, 16'd4);
    step();
    pulse(1'b1, 1'b0);
    checks++; if (bus.sample_addr !== 20'h00000) begin errors++; $display("FAIL wrap_0: got %h exp 00000", bus.sample_addr); end
    pulse(1'b1, 1'b0);
    checks++; if (bus.sample_addr !== 20'h00001) begin errors++; $display("FAIL wrap_1: got %h exp 00001", bus.sample_addr); end
    bus.key_valid = 1'b1;
    bus.note_base = 20'h00200;
    bus.note_len  = 16'd1;
    #1;
    checks++; if (bus.key_ready !== 1'b0) begin errors++; $display("FAIL play_not_ready: got %b exp 0", bus.key_ready); end
    for (int i = 0; i < 4; i++) begin
      pulse(1'b0, 1'b1);
      checks++; if ({bus.count_done, bus.new_note} !== {(i == 3), 1'b0}) begin errors++; $display("FAIL pending_play i=%0d: count_done,new_note got %b exp %b0", i, {bus.count_done, bus.new_note}, (i == 3)); end
      checks++; if (bus.sample_addr !== 20'h00001) begin errors++; $display("FAIL no_retrigger i=%0d: addr got %h exp 00001", i, bus.sample_addr); end
    end
    step();
    checks++; if ({bus.key_ready, bus.new_note} !== 2'b00) begin errors++; $display("FAIL pending_done: key_ready,new_note got %b exp 00", {bus.key_ready, bus.new_note}); end
    step();
    checks++; if ({bus.key_ready, bus.new_note} !== 2'b10) begin errors++; $display("FAIL pending_idle: key_ready,new_note got %b exp 10", {bus.key_ready, bus.new_note}); end
    step();
    bus.key_valid = 1'b0;
    checks++; if ({bus.new_note, bus.sample_addr} !== {1'b1, 20'h00200}) begin errors++; $display("FAIL pending_accept: new_note,addr got %b,%h exp 1,00200", bus.new_note, bus.sample_addr); end
    step();
    pulse(1'b0, 1'b1);
    checks++; if (bus.count_done !== 1'b1) begin errors++; $display("FAIL pending_len1: got %b exp 1", bus.count_done); end
    step();
    step();
  endtask

  task automatic test_reset_mid_play();
    accept_note(20'h00300, 16'd10);
    step();
    repeat (5) pulse(1'b1, 1'b1);
    checks++; if ({bus.sample_addr, bus.count_done} !== {20'h00305, 1'b0}) begin errors++; $display("FAIL mid_play: addr,count_done got %h,%b exp 00305,0", bus.sample_addr, bus.count_done); end
    Reset = 1'b1;
    step();
    checks++; if (bus.sample_addr !== 20'h0) begin errors++; $display("FAIL abort_addr: got %h exp 00000", bus.sample_addr); end
    checks++; if ({bus.count_done, bus.busy, bus.key_ready, bus.new_note, bus.ctrl_init} !== 5'b0) begin errors++; $display("FAIL abort_flags: got %b exp 00000", {bus.count_done, bus.busy, bus.key_ready, bus.new_note, bus.ctrl_init}); end
    Reset = 1'b0;
    step();
    checks++; if ({bus.ctrl_init, bus.key_ready} !== 2'b10) begin errors++; $display("FAIL reinit_pulse: ctrl_init,key_ready got %b exp 10", {bus.ctrl_init, bus.key_ready}); end
    step();
    checks++; if ({bus.ctrl_init, bus.key_ready} !== 2'b01) begin errors++; $display("FAIL reinit_idle: ctrl_init,key_ready got %b exp 01", {bus.ctrl_init, bus.key_ready}); end
  endtask

  initial begin
    bus.key_valid = 1'b0;
    bus.note_base = '0;
    bus.note_len  = '0;
    bus.increment = 1'b0;
    bus.count_inc = 1'b0;
    test_reset();
    test_basic_note();
    test_len_zero();
    test_wrap_and_pending_key();
    test_reset_mid_play();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
